// File: rtl/gearbox_rx_32b_if.sv
// Receive gearbox bundle: PMA word stream in, aligned 66-bit block halves out.
// The slave side is the gearbox; the master side is the PMA feed and block sink.
interface gearbox_rx_32b_if;
  logic [31:0] pma_data;
  logic [31:0] dout;
  logic [1:0]  ctrl;
  logic        dout_en;
  logic        even;
  logic        block_lock;
  logic [7:0]  slip_cnt;

  modport master (
    output pma_data,
    input  dout, ctrl, dout_en, even, block_lock, slip_cnt
  );

  modport slave (
    input  pma_data,
    output dout, ctrl, dout_en, even, block_lock, slip_cnt
  );
endinterface

// File: rtl/gearbox_rx_32b.sv
// 32-to-66 receive gearbox with bit-slip block lock search.
// Blocks are emitted as two halves; lock is judged on the sync header.
module gearbox_rx_32b #(
  parameter int LOCK_CNT    = 64,
  parameter int INVALID_MAX = 16,
  parameter int SLIP_WAIT   = 4
) (
  input  logic clk,
  input  logic rst,
  gearbox_rx_32b_if.slave gb
);

  localparam int SHW = $clog2(LOCK_CNT + 1);
  localparam int INW = $clog2(INVALID_MAX + 1);
  localparam int WTW = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {
    LOCK_INIT,
    RESET_CNT,
    TEST_SH,
    SLIP
  } state_t;

  logic [127:0] bits_q;
  logic [6:0]   fill_q;
  logic         hi_pend_q;
  logic [31:0]  hi_q;
  logic         slip_q;

  logic [31:0]  dout_q;
  logic [1:0]   ctrl_q;
  logic         dout_en_q;
  logic         even_q;

  state_t       state_q;
  logic         lock_q;
  logic [SHW-1:0] sh_cnt_q;
  logic [INW-1:0] inv_cnt_q;
  logic [WTW-1:0] wait_q;
  logic [7:0]   slip_cnt_q;

  logic [127:0] merged;
  logic [7:0]   mfill;
  logic         take;
  logic         hdr_evt;
  logic         hdr_ok;
  logic [SHW-1:0] sh_n;
  logic [INW-1:0] inv_n;

  // Append the new word behind the buffered bits, dropping one bit on slip.
  always_comb begin
    merged = bits_q | ({96'b0, gb.pma_data} << fill_q);
    mfill  = {1'b0, fill_q} + 8'd32;
    if (slip_q) begin
      merged = merged >> 1;
      mfill  = mfill - 8'd1;
    end
    take    = !hi_pend_q && (mfill >= 8'd66);
    hdr_evt = dout_en_q && even_q;
    hdr_ok  = ^ctrl_q;
    sh_n    = sh_cnt_q + SHW'(1);
    inv_n   = inv_cnt_q + INW'(1);
  end

  // Cut a whole block out when one is ready, then send its upper half.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bits_q    <= '0;
      fill_q    <= '0;
      hi_pend_q <= 1'b0;
      hi_q      <= '0;
      dout_q    <= '0;
      ctrl_q    <= '0;
      dout_en_q <= 1'b0;
      even_q    <= 1'b0;
    end else if (take) begin
      bits_q    <= merged >> 66;
      fill_q    <= 7'(mfill - 8'd66);
      hi_pend_q <= 1'b1;
      hi_q      <= merged[65:34];
      dout_q    <= merged[33:2];
      ctrl_q    <= merged[1:0];
      dout_en_q <= 1'b1;
      even_q    <= 1'b1;
    end else begin
      bits_q    <= merged;
      fill_q    <= mfill[6:0];
      hi_pend_q <= 1'b0;
      dout_en_q <= hi_pend_q;
      even_q    <= 1'b0;
      if (hi_pend_q) begin
        dout_q <= hi_q;
      end
    end
  end

  // Block lock search and monitoring, one header per emitted block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LOCK_INIT;
      lock_q     <= 1'b0;
      sh_cnt_q   <= '0;
      inv_cnt_q  <= '0;
      wait_q     <= '0;
      slip_q     <= 1'b0;
      slip_cnt_q <= '0;
    end else begin
      slip_q <= 1'b0;
      unique case (state_q)
        LOCK_INIT: begin
          lock_q  <= 1'b0;
          state_q <= RESET_CNT;
        end
        RESET_CNT: begin
          sh_cnt_q  <= '0;
          inv_cnt_q <= '0;
          state_q   <= TEST_SH;
        end
        TEST_SH: begin
          if (hdr_evt) begin
            sh_cnt_q <= sh_n;
            if (hdr_ok) begin
              if (sh_n == SHW'(LOCK_CNT)) begin
                if (inv_cnt_q == '0) begin
                  lock_q <= 1'b1;
                end
                state_q <= RESET_CNT;
              end
            end else begin
              inv_cnt_q <= inv_n;
              if (!lock_q || inv_n == INW'(INVALID_MAX)) begin
                lock_q  <= 1'b0;
                slip_q  <= 1'b1;
                wait_q  <= '0;
                state_q <= SLIP;
                if (slip_cnt_q != 8'hff) begin
                  slip_cnt_q <= slip_cnt_q + 8'd1;
                end
              end else if (sh_n == SHW'(LOCK_CNT)) begin
                state_q <= RESET_CNT;
              end
            end
          end
        end
        SLIP: begin
          if (hdr_evt) begin
            if (wait_q == WTW'(SLIP_WAIT - 1)) begin
              state_q <= RESET_CNT;
            end else begin
              wait_q <= wait_q + WTW'(1);
            end
          end
        end
        default: state_q <= LOCK_INIT;
      endcase
    end
  end

  assign gb.dout       = dout_q;
  assign gb.ctrl       = ctrl_q;
  assign gb.dout_en    = dout_en_q;
  assign gb.even       = even_q;
  assign gb.block_lock = lock_q;
  assign gb.slip_cnt   = slip_cnt_q;

endmodule
